// File: rtl/ps2_frame_rx.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// ps2_frame_rx
//
// Front end of the keyboard path. Receives PS/2 device-to-host frames
// (start, d0..d7, odd parity, stop; LSB first), checks the spacing of the
// ps2Clk falling edges and the frame format, and presents each good byte on
// `data` with a level-style `dataReady`. A sticky `error` flags any malformed
// or mistimed frame; it clears at the next start edge or on reset.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   ps2Clk     in   raw PS/2 clock from the pad (asynchronous)
//   ps2Data    in   raw PS/2 data from the pad (asynchronous)
//   data       out  [7:0] last validly received byte
//   dataReady  out  high while `data` holds a fresh byte; drops at next start
//   error      out  sticky frame/timing fault flag
//
// Parameters:
//   counterBits  width of the saturating clk-cycle interval counter
//   minClk       shortest legal spacing (clk cycles) between in-frame falls
//   maxClk       longest legal spacing; also the in-frame timeout
//   readAt       clk cycles after a synchronized fall at which data is sampled
// ----------------------------------------------------------------------------
module ps2_frame_rx #(
    parameter int counterBits = 8,
    parameter int minClk      = 15,
    parameter int maxClk      = 25,
    parameter int readAt      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] data,
    output logic       dataReady,
    output logic       error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [counterBits-1:0] CNT_MAX = {counterBits{1'b1}};
    localparam logic [counterBits-1:0] MIN_C   = counterBits'(minClk);
    localparam logic [counterBits-1:0] MAX_C   = counterBits'(maxClk);
    localparam logic [counterBits-1:0] READ_C  = counterBits'(readAt);
    localparam logic [3:0]             LAST_BIT = 4'd10;

    // True when the nine bits (d0..d7 plus parity) hold an odd number of ones.
    function automatic logic odd_ones(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Synchronizers; they idle high like the bus itself.
    logic clk_meta_r;
    logic clk_sync_r;
    logic clk_prev_r;
    logic data_meta_r;
    logic data_sync_r;
    logic fall_s;

    // Interval counter and its "cycles since the last fall" view.
    logic [counterBits-1:0] cnt_r;
    logic [counterBits-1:0] elapsed_s;

    // FSM and frame datapath.
    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  bit_idx_r;
    logic [10:0] frame_r;
    logic [7:0]  data_r;
    logic        ready_r;
    logic        err_r;

    // Timing events and datapath strobes.
    logic timeout_s;
    logic bad_fall_s;
    logic sample_s;
    logic frame_ok_s;
    logic start_s;
    logic abort_s;
    logic take_s;
    logic accept_s;
    logic reject_s;

    // Two-flop synchronizers for both pad inputs plus the previous clock level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            clk_prev_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2Clk;
            clk_sync_r  <= clk_meta_r;
            clk_prev_r  <= clk_sync_r;
            data_meta_r <= ps2Data;
            data_sync_r <= data_meta_r;
        end
    end

    assign fall_s = clk_prev_r & ~clk_sync_r;

    // cnt_r is cleared by a fall and reads 0 the cycle after it, so the
    // saturated increment equals the number of cycles since the last fall,
    // including in the cycle of the next fall where the spacing is judged.
    assign elapsed_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + counterBits'(1));

    // Saturating interval counter, restarted by every synchronized fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {counterBits{1'b0}};
        end else if (fall_s) begin
            cnt_r <= {counterBits{1'b0}};
        end else begin
            cnt_r <= elapsed_s;
        end
    end

    // A timeout outranks a fall arriving in the same cycle, so such a fall
    // is never mistaken for a new start bit.
    assign timeout_s  = (elapsed_s > MAX_C);
    assign bad_fall_s = fall_s & ((elapsed_s < MIN_C) | (elapsed_s > MAX_C));
    assign sample_s   = ~fall_s & (elapsed_s == READ_C);
    assign frame_ok_s = ~frame_r[0] & frame_r[10] & odd_ones(frame_r[9:1]);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nxt_s = ST_FRAME;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (timeout_s || bad_fall_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (sample_s && (bit_idx_r == LAST_BIT)) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_FRAME;
                end
            end
            ST_CHECK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: one datapath strobe per cycle at most.
    always_comb begin
        start_s  = 1'b0;
        abort_s  = 1'b0;
        take_s   = 1'b0;
        accept_s = 1'b0;
        reject_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s = fall_s;
            end
            ST_FRAME: begin
                if (timeout_s || bad_fall_s) begin
                    abort_s = 1'b1;
                end else if (sample_s) begin
                    take_s = 1'b1;
                end else begin
                    take_s = 1'b0;
                end
            end
            ST_CHECK: begin
                if (frame_ok_s) begin
                    accept_s = 1'b1;
                end else begin
                    reject_s = 1'b1;
                end
            end
            default: begin
                abort_s = 1'b0;
            end
        endcase
    end

    // Frame datapath: bit capture, delivered byte and the two status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx_r <= 4'd0;
            frame_r   <= 11'd0;
            data_r    <= 8'd0;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
        end else if (start_s) begin
            bit_idx_r <= 4'd0;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
        end else if (abort_s) begin
            err_r <= 1'b1;
        end else if (take_s) begin
            for (int i = 0; i < 11; i++) begin
                if (bit_idx_r == 4'(i)) begin
                    frame_r[i] <= data_sync_r;
                end
            end
            bit_idx_r <= bit_idx_r + 4'd1;
        end else if (accept_s) begin
            data_r  <= frame_r[8:1];
            ready_r <= 1'b1;
        end else if (reject_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign data      = data_r;
    assign dataReady = ready_r;
    assign error     = err_r;

endmodule

// File: tb/tb_ps2_frame_rx.sv
`timescale 1ns/1ps
module tb_ps2_frame_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2Clk;
    logic       ps2Data;
    logic [7:0] data;
    logic       dataReady;
    logic       error;

    int checks   = 0;
    int failures = 0;
    int rises    = 0;
    logic ready_q = 1'b0;

    ps2_frame_rx #(
        .counterBits(8),
        .minClk(15),
        .maxClk(25),
        .readAt(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2Clk(ps2Clk),
        .ps2Data(ps2Data),
        .data(data),
        .dataReady(dataReady),
        .error(error)
    );

    always #5 clk = ~clk;

    // Count dataReady rising edges, sampled on the inactive edge.
    always @(negedge clk) begin
        if (dataReady && !ready_q) begin
            rises <= rises + 1;
        end
        ready_q <= dataReady;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic       start;
        int         nfalls;
        int         odd_idx;
        int         odd_iv;
        logic       exp_ready;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drives falls 0..nfalls-1 of a frame (bit 0 first). The interval between
    // fall i-1 and fall i is 20 clk, or odd_iv when i == odd_idx. Returns right
    // after the last fall with ps2Clk still low. With skip_start the caller has
    // already produced the start fall.
    task automatic send(input logic [10:0] bits, input int nfalls,
                        input int odd_idx, input int odd_iv, input bit skip_start);
        int iv;
        if (!skip_start) begin
            ps2Data = bits[0];
            cyc(5);
            ps2Clk = 1'b0;
        end
        for (int i = 1; i < nfalls; i++) begin
            iv = (i == odd_idx) ? odd_iv : 20;
            cyc(8);
            ps2Clk  = 1'b1;
            ps2Data = bits[i];
            cyc(iv - 8);
            ps2Clk = 1'b0;
        end
    endtask

    task automatic release_clk();
        cyc(8);
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
    endtask

    initial begin
        logic [10:0] bits;
        int r0;

        //              d      par   stop  start n   idx iv  rdy   data   err
        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 11, 0,  20, 1'b1, 8'h1C, 1'b0};
        vecs[1]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 11, 0,  20, 1'b0, 8'h1C, 1'b1};
        vecs[2]  = '{8'hF0, 1'b1, 1'b1, 1'b0, 11, 0,  20, 1'b1, 8'hF0, 1'b0};
        vecs[3]  = '{8'h16, 1'b0, 1'b1, 1'b0, 4,  3,  12, 1'b0, 8'hF0, 1'b1};
        vecs[4]  = '{8'h16, 1'b0, 1'b1, 1'b0, 11, 0,  20, 1'b1, 8'h16, 1'b0};
        vecs[5]  = '{8'h16, 1'b0, 1'b0, 1'b0, 11, 0,  20, 1'b0, 8'h16, 1'b1};
        vecs[6]  = '{8'h33, 1'b1, 1'b1, 1'b1, 11, 0,  20, 1'b0, 8'h16, 1'b1};
        vecs[7]  = '{8'h00, 1'b1, 1'b1, 1'b0, 11, 0,  20, 1'b1, 8'h00, 1'b0};
        vecs[8]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 11, 5,  15, 1'b1, 8'hA5, 1'b0};
        vecs[9]  = '{8'h3C, 1'b1, 1'b1, 1'b0, 11, 7,  25, 1'b1, 8'h3C, 1'b0};
        vecs[10] = '{8'h3C, 1'b1, 1'b1, 1'b0, 3,  2,  14, 1'b0, 8'h3C, 1'b1};
        vecs[11] = '{8'hFF, 1'b1, 1'b1, 1'b0, 6,  5,  26, 1'b0, 8'h3C, 1'b1};
        vecs[12] = '{8'hFF, 1'b1, 1'b1, 1'b0, 11, 0,  20, 1'b1, 8'hFF, 1'b0};

        // Reset state.
        reset   = 1'b1;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        cyc(3);
        chk8("reset data", data, 8'h00);
        chk1("reset dataReady", dataReady, 1'b0);
        chk1("reset error", error, 1'b0);
        reset = 1'b0;
        cyc(10);

        // Table of frames; outputs checked 15 clk after the last pad fall.
        for (int i = 0; i < 13; i++) begin
            bits = {vecs[i].stop, vecs[i].par, vecs[i].d, vecs[i].start};
            send(bits, vecs[i].nfalls, vecs[i].odd_idx, vecs[i].odd_iv, 1'b0);
            release_clk();
            cyc(7);
            chk1($sformatf("vec%0d dataReady", i), dataReady, vecs[i].exp_ready);
            chk8($sformatf("vec%0d data", i), data, vecs[i].exp_data);
            chk1($sformatf("vec%0d error", i), error, vecs[i].exp_err);
            cyc(20);
        end

        // dataReady holds until the next start; back-to-back F0 then 1C.
        chk1("hold dataReady", dataReady, 1'b1);
        r0 = rises;
        send({1'b1, 1'b1, 8'hF0, 1'b0}, 11, 0, 20, 1'b0);
        release_clk();
        cyc(4);
        chk1("b2b first ready", dataReady, 1'b1);
        chk8("b2b first data", data, 8'hF0);
        ps2Data = 1'b0;
        cyc(5);
        ps2Clk = 1'b0;
        // The pad fall reaches the FSM after two synchronizer stages; the
        // start strobe clears dataReady on the following edge.
        cyc(2);
        chk1("b2b ready before start", dataReady, 1'b1);
        cyc(1);
        chk1("b2b ready dropped", dataReady, 1'b0);
        send({1'b1, 1'b0, 8'h1C, 1'b0}, 11, 0, 20, 1'b1);
        // Sample at readAt after the synchronized fall, check one cycle later,
        // registered on the next edge: 9 edges after the pad fall.
        release_clk();
        chk1("latency ready low", dataReady, 1'b0);
        cyc(1);
        chk1("latency ready high", dataReady, 1'b1);
        chk8("b2b second data", data, 8'h1C);
        cyc(2);
        checks++;
        if (rises - r0 != 2) begin
            failures++;
            $display("FAIL b2b rising edges: got %0d expected 2", rises - r0);
        end
        cyc(20);

        // Device stops clocking after 4 falls. The synchronized fall lands 2
        // cycles after the pad edge, the timeout is judged 26 cycles later and
        // error registers on the next edge: first seen 29 clk after the pad fall.
        send({1'b1, 1'b0, 8'h55, 1'b0}, 4, 0, 20, 1'b0);
        cyc(8);
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        cyc(20);
        chk1("timeout error not yet", error, 1'b0);
        cyc(1);
        chk1("timeout error", error, 1'b1);
        chk1("timeout dataReady", dataReady, 1'b0);
        chk8("timeout data", data, 8'h1C);
        cyc(20);

        // Reset in the middle of a frame, then a clean 0x5A frame.
        send({1'b1, 1'b1, 8'h5A, 1'b0}, 6, 0, 20, 1'b0);
        cyc(3);
        reset   = 1'b1;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        cyc(2);
        chk8("midreset data", data, 8'h00);
        chk1("midreset dataReady", dataReady, 1'b0);
        chk1("midreset error", error, 1'b0);
        reset = 1'b0;
        cyc(40);
        chk1("postreset quiet ready", dataReady, 1'b0);
        chk1("postreset quiet error", error, 1'b0);
        send({1'b1, 1'b1, 8'h5A, 1'b0}, 11, 0, 20, 1'b0);
        release_clk();
        cyc(7);
        chk1("5A dataReady", dataReady, 1'b1);
        chk8("5A data", data, 8'h5A);
        chk1("5A error", error, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
